pico_mm_timer: RTL and testbench
================================

PICO_MM_TIMER -- requirements
Module: pico_mm_timer

Interface
REQ-001 Parameter PSC_W, default 16, prescaler register width (1..32).
REQ-002 Parameter RST_LOAD, default 32'hFFFF_FFFF, reset value of LOAD.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port s  PicoMmIf.slave  AW>=3 (addr), 32 (wrdata/rddata)  bus slave; sits downstream of the PicoMm interconnect as one of its masters' targets.
REQ-006 Port cap_in  input  1  asynchronous capture strobe; used only when PICO_MM_TIMER_CAPTURE_EN is defined.
REQ-007 Port irq  output  1  level interrupt, registered.

Function
REQ-008 Word-addressed register map on s.addr[2:0]: 0 CTRL, 1 PSC, 2 LOAD, 3 COUNT, 4 STATUS, 5 CAPTURE; offsets 6-7 and higher addr bits are ignored for decode.
REQ-009 CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
REQ-010 Write (s.write=1) takes effect on that rising edge; writes to unused offsets or read-only CAPTURE are ignored.
REQ-011 Read latency is exactly 1 cycle: s.rddata is registered, valid the cycle after s.read=1, and holds until the next read; unused offsets return 0.
REQ-012 Prescaler: psc_cnt increments while EN=1; when psc_cnt==PSC, psc_cnt wraps to 0 and a one-cycle tick is generated (PSC=0 gives a tick every cycle).
REQ-013 On tick with COUNT!=0: COUNT decrements by 1.
REQ-014 On tick with COUNT==0: STATUS[0] (EXPIRED) sets; if AUTO_RELOAD=1, COUNT<=LOAD; otherwise COUNT stays 0 and EN clears.
REQ-015 Writing CTRL with EN transitioning 0->1 clears psc_cnt; EN=0 freezes psc_cnt and COUNT.
REQ-016 A bus write to COUNT takes priority over a same-cycle tick decrement/reload.
REQ-017 STATUS is write-1-to-clear; a same-cycle new set event wins over the clear.
REQ-018 irq <= |(STATUS & {..., IRQ_EN}) registered, i.e. irq asserts 1 cycle after EXPIRED sets with IRQ_EN=1.
REQ-019 A read returning COUNT returns the value before any same-cycle update.

Reset
REQ-020 On rst: CTRL=0, PSC=0, LOAD=RST_LOAD, COUNT=0, STATUS=0, CAPTURE=0, psc_cnt=0, s.rddata=0, irq=0, capture synchroniser cleared.
REQ-021 Reset asserted mid-count aborts all activity; no tick, expiry or irq is produced until EN is written 1 again.

Configuration
REQ-022 Macro PICO_MM_TIMER_CAPTURE_EN defined: cap_in passes a 2-flop synchroniser plus edge detector; on each rising edge CAPTURE<=COUNT and STATUS[1] (CAPTURED) sets, contributing to irq when IRQ_EN=1; total cap_in-to-CAPTURE latency 3 cycles.
REQ-023 Macro not defined: cap_in ignored, CAPTURE and STATUS[1] read 0, no synchroniser flops instantiated.

Structure
REQ-024 Package pico_mm_timer_pkg holds register offset constants, CTRL/STATUS bit-index constants and a typedef for the CTRL register struct.
REQ-025 One sub-module, pico_mm_edge_sync (2-flop synchroniser + rising-edge pulse, async active-high reset), instantiated only under PICO_MM_TIMER_CAPTURE_EN.

Verification
REQ-026 Reset then read all offsets 0-7 -> LOAD reads 32'hFFFF_FFFF, all others 0, irq=0.
REQ-027 PSC=3, COUNT=2, CTRL=3'b101 -> EXPIRED sets on 12th cycle after EN, irq rises 1 cycle later, EN reads 0, COUNT holds 0.
REQ-028 PSC=0, LOAD=1, COUNT=0, CTRL=3'b011 -> EXPIRED sets every 2 cycles, COUNT sequence 1,0,1,0.
REQ-029 Write STATUS=1 in the same cycle as a new expiry -> EXPIRED remains 1; write STATUS=1 later -> EXPIRED 0 and irq drops next cycle.
REQ-030 Write COUNT=100 coincident with a tick -> COUNT reads 100, not 99; read of COUNT issued at cycle N returns data at N+1.
REQ-031 With PICO_MM_TIMER_CAPTURE_EN: pulse cap_in while COUNT=50 (frozen, EN=0) -> CAPTURE reads 50 and STATUS[1]=1 after 3 cycles; without the macro CAPTURE reads 0.

Source files
------------

// File: rtl/pico_mm_timer_pkg.sv
// Register map, bit positions and the CTRL register layout shared by the PicoMm timer.
package pico_mm_timer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OFF_W  = 3;
   localparam int unsigned STAT_W = 2;

   localparam logic [OFF_W-1:0] OFF_CTRL    = 3'd0;
   localparam logic [OFF_W-1:0] OFF_PSC     = 3'd1;
   localparam logic [OFF_W-1:0] OFF_LOAD    = 3'd2;
   localparam logic [OFF_W-1:0] OFF_COUNT   = 3'd3;
   localparam logic [OFF_W-1:0] OFF_STATUS  = 3'd4;
   localparam logic [OFF_W-1:0] OFF_CAPTURE = 3'd5;

   localparam int unsigned CTRL_EN_BIT     = 0;
   localparam int unsigned CTRL_AUTO_BIT   = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT = 2;

   localparam int unsigned STAT_EXPIRED_BIT  = 0;
   localparam int unsigned STAT_CAPTURED_BIT = 1;

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } ctrl_t;

   function automatic ctrl_t ctrl_from_word(input logic [DATA_W-1:0] w);
      ctrl_t c;
      c.irq_en      = w[CTRL_IRQ_EN_BIT];
      c.auto_reload = w[CTRL_AUTO_BIT];
      c.en          = w[CTRL_EN_BIT];
      return c;
   endfunction

endpackage

// File: rtl/pico_mm_if.sv
// PicoMm word-addressed bus: single-cycle writes, registered one-cycle read data.
interface PicoMmIf #(
   parameter int unsigned AW = 3
);
   logic [AW-1:0] addr;
   logic          write;
   logic          read;
   logic [31:0]   wrdata;
   logic [31:0]   rddata;

   modport slave  (input addr, write, read, wrdata, output rddata);
   modport master (output addr, write, read, wrdata, input rddata);
endinterface

// File: rtl/pico_mm_edge_sync.sv
// Two-flop synchroniser for an asynchronous strobe plus a one-cycle rising-edge pulse.
module pico_mm_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise_c
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/pico_mm_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and level irq.
// Optional input capture is built when PICO_MM_TIMER_CAPTURE_EN is defined.
module pico_mm_timer
   import pico_mm_timer_pkg::*;
#(
   parameter int unsigned PSC_W    = 16,
   parameter logic [31:0] RST_LOAD = 32'hFFFF_FFFF
) (
   input  logic    clk,
   input  logic    rst,
   PicoMmIf.slave  s,
   input  logic    cap_in,
   output logic    irq
);

   ctrl_t               ctrl_q,    ctrl_d;
   logic [PSC_W-1:0]    psc_q,     psc_d;
   logic [PSC_W-1:0]    psc_cnt_q, psc_cnt_d;
   logic [DATA_W-1:0]   load_q,    load_d;
   logic [DATA_W-1:0]   count_q,   count_d;
   logic [STAT_W-1:0]   status_q,  status_d;
   logic [DATA_W-1:0]   rddata_q,  rddata_d;
   logic                irq_q,     irq_d;
   logic [DATA_W-1:0]   capture_q;

   logic [OFF_W-1:0]    off_c;
   logic                wr_ctrl_c, wr_psc_c, wr_load_c, wr_count_c, wr_status_c;
   ctrl_t               wr_ctrl_val_c;
   logic                tick_c;
   logic                expire_c;
   logic                cap_rise_c;
   logic [STAT_W-1:0]   stat_set_c, stat_clr_c;
   logic                unused_addr;

   assign off_c         = s.addr[OFF_W-1:0];
   assign unused_addr   = ^s.addr;
   assign wr_ctrl_c     = s.write && (off_c == OFF_CTRL);
   assign wr_psc_c      = s.write && (off_c == OFF_PSC);
   assign wr_load_c     = s.write && (off_c == OFF_LOAD);
   assign wr_count_c    = s.write && (off_c == OFF_COUNT);
   assign wr_status_c   = s.write && (off_c == OFF_STATUS);
   assign wr_ctrl_val_c = ctrl_from_word(s.wrdata);

   assign tick_c   = ctrl_q.en && (psc_cnt_q == psc_q);
   assign expire_c = tick_c && (count_q == '0);

`ifdef PICO_MM_TIMER_CAPTURE_EN
   pico_mm_edge_sync u_cap_sync (
      .clk    (clk),
      .rst    (rst),
      .din    (cap_in),
      .rise_c (cap_rise_c)
   );

   // Snapshot of COUNT as it stands on the synchronised capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         capture_q <= '0;
      else if (cap_rise_c)
         capture_q <= count_q;
   end
`else
   logic unused_cap;
   assign unused_cap = cap_in;
   assign cap_rise_c = 1'b0;
   assign capture_q  = '0;
`endif

   always_comb begin
      ctrl_d     = ctrl_q;
      psc_d      = psc_q;
      psc_cnt_d  = psc_cnt_q;
      load_d     = load_q;
      count_d    = count_q;
      status_d   = status_q;
      rddata_d   = rddata_q;
      irq_d      = 1'b0;
      stat_set_c = '0;
      stat_clr_c = '0;

      // A CTRL write overrides the self-clearing of EN on a one-shot expiry.
      if (wr_ctrl_c)
         ctrl_d = wr_ctrl_val_c;
      else if (expire_c && !ctrl_q.auto_reload)
         ctrl_d.en = 1'b0;

      if (wr_psc_c)
         psc_d = s.wrdata[PSC_W-1:0];
      if (wr_load_c)
         load_d = s.wrdata;

      if (wr_ctrl_c && wr_ctrl_val_c.en && !ctrl_q.en)
         psc_cnt_d = '0;
      else if (ctrl_q.en)
         psc_cnt_d = tick_c ? '0 : psc_cnt_q + PSC_W'(1);

      // Bus write to COUNT beats a coincident decrement or reload.
      if (wr_count_c)
         count_d = s.wrdata;
      else if (tick_c) begin
         if (count_q != '0)
            count_d = count_q - DATA_W'(1);
         else if (ctrl_q.auto_reload)
            count_d = load_q;
      end

      stat_set_c[STAT_EXPIRED_BIT]  = expire_c;
      stat_set_c[STAT_CAPTURED_BIT] = cap_rise_c;
      if (wr_status_c)
         stat_clr_c = s.wrdata[STAT_W-1:0];
      status_d = stat_set_c | (status_q & ~stat_clr_c);

      irq_d = |(status_q & {STAT_W{ctrl_q.irq_en}});

      if (s.read) begin
         case (off_c)
            OFF_CTRL:    rddata_d = DATA_W'(ctrl_q);
            OFF_PSC:     rddata_d = DATA_W'(psc_q);
            OFF_LOAD:    rddata_d = load_q;
            OFF_COUNT:   rddata_d = count_q;
            OFF_STATUS:  rddata_d = DATA_W'(status_q);
            OFF_CAPTURE: rddata_d = capture_q;
            default:     rddata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= '0;
         psc_q     <= '0;
         psc_cnt_q <= '0;
         load_q    <= RST_LOAD;
         count_q   <= '0;
         status_q  <= '0;
         rddata_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         psc_q     <= psc_d;
         psc_cnt_q <= psc_cnt_d;
         load_q    <= load_d;
         count_q   <= count_d;
         status_q  <= status_d;
         rddata_q  <= rddata_d;
         irq_q     <= irq_d;
      end
   end

   assign s.rddata = rddata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_pico_mm_timer.sv
// Directed bench for pico_mm_timer: register-map vectors plus timing sequences.
module tb_pico_mm_timer;

   logic clk;
   logic rst;
   logic cap_in;
   logic irq;

   PicoMmIf #(.AW(3)) bus ();

   pico_mm_timer dut (
      .clk    (clk),
      .rst    (rst),
      .s      (bus.slave),
      .cap_in (cap_in),
      .irq    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic        do_wr;
      logic [2:0]  waddr;
      logic [31:0] wdata;
      logic [2:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.addr   = a;
      bus.wrdata = d;
      bus.write  = 1'b1;
      tick_cycle();
      bus.write  = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.addr = a;
      bus.read = 1'b1;
      tick_cycle();
      bus.read = 1'b0;
      d = bus.rddata;
   endtask

   initial begin
      logic [31:0] rd;
      int cycles;
      logic irq_seen;
      logic [31:0] exp_cap;
      logic [31:0] exp_stat;

      n_cmp  = 0;
      n_fail = 0;

      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b0, 3'd0, 32'h0, 3'(i), (i == 2) ? 32'hFFFF_FFFF : 32'h0};
      vecs[8]  = '{1'b1, 3'd1, 32'h0001_0003, 3'd1, 32'h0000_0003};
      vecs[9]  = '{1'b1, 3'd0, 32'hFFFF_FFFE, 3'd0, 32'h0000_0006};
      vecs[10] = '{1'b1, 3'd2, 32'h1234_5678, 3'd2, 32'h1234_5678};
      vecs[11] = '{1'b1, 3'd3, 32'd77,        3'd3, 32'd77};
      vecs[12] = '{1'b1, 3'd5, 32'hDEAD_BEEF, 3'd5, 32'h0};
      vecs[13] = '{1'b1, 3'd6, 32'h0000_0001, 3'd0, 32'h0000_0006};
      vecs[14] = '{1'b1, 3'd7, 32'h0,         3'd2, 32'h1234_5678};
      vecs[15] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 3'd4, 32'h0};

      rst = 1'b1;
      cap_in = 1'b0;
      bus.addr = '0;
      bus.write = 1'b0;
      bus.read = 1'b0;
      bus.wrdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rddata", bus.rddata, 32'h0);
      rst = 1'b0;
      tick_cycle();
      check("reset_irq", {31'b0, irq}, 32'h0);

      // Register map: reset values, then write/read-back with EN held low.
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].do_wr)
            bus_write(vecs[i].waddr, vecs[i].wdata);
         bus_read(vecs[i].raddr, rd);
         n_cmp++;
         if (rd !== vecs[i].exp) begin
            n_fail++;
            $display("FAIL vec[%0d]: got %h, want %h", i, rd, vecs[i].exp);
         end
      end

      // One-shot: PSC=3, COUNT=2 expires on the 12th edge, irq on the 13th.
      bus_write(3'd1, 32'd3);
      bus_write(3'd3, 32'd2);
      bus_write(3'd0, 32'h5);
      cycles = 0;
      while (!irq && cycles < 40) begin
         tick_cycle();
         cycles++;
      end
      check("oneshot_irq_latency", 32'(cycles), 32'd13);
      bus_read(3'd0, rd);
      check("oneshot_ctrl_en_clear", rd, 32'h4);
      bus_read(3'd3, rd);
      check("oneshot_count_zero", rd, 32'h0);
      bus_read(3'd4, rd);
      check("oneshot_status", rd, 32'h1);

      // Clearing EXPIRED with no new event: irq drops one cycle later.
      bus_write(3'd4, 32'h1);
      check("clr_irq_still_high", {31'b0, irq}, 32'h1);
      tick_cycle();
      check("clr_irq_dropped", {31'b0, irq}, 32'h0);
      bus_read(3'd4, rd);
      check("clr_status", rd, 32'h0);

      // Auto-reload: PSC=0, LOAD=1, COUNT=0 -> COUNT 1,0,1,0.
      bus_write(3'd1, 32'd0);
      bus_write(3'd2, 32'd1);
      bus_write(3'd3, 32'd0);
      bus_write(3'd0, 32'h3);
      tick_cycle();
      for (int k = 0; k < 4; k++) begin
         bus_read(3'd3, rd);
         check($sformatf("reload_count[%0d]", k), rd, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      // Next expiry lands two edges after the last one; clear it coincidently.
      tick_cycle();
      bus_write(3'd4, 32'h1);
      bus_read(3'd4, rd);
      check("set_beats_clear", rd, 32'h1);
      bus_write(3'd0, 32'h0);
      bus_write(3'd4, 32'h1);
      bus_read(3'd4, rd);
      check("stopped_status_clear", rd, 32'h0);

      // COUNT write coincident with a tick (PSC=0 ticks every cycle).
      bus_write(3'd3, 32'd500);
      bus_write(3'd0, 32'h1);
      bus_write(3'd3, 32'd100);
      bus_read(3'd3, rd);
      check("count_write_priority", rd, 32'd100);
      bus_read(3'd3, rd);
      check("count_next_decrement", rd, 32'd99);
      bus_write(3'd0, 32'h0);
      tick_cycle();
      check("rddata_holds", bus.rddata, 32'd99);

      // Capture with COUNT frozen at 50.
      bus_write(3'd3, 32'd50);
      cap_in = 1'b1;
      tick_cycle();
      tick_cycle();
      bus_read(3'd5, rd);
      check("capture_before_latency", rd, 32'h0);
`ifdef PICO_MM_TIMER_CAPTURE_EN
      exp_cap  = 32'd50;
      exp_stat = 32'h2;
`else
      exp_cap  = 32'd0;
      exp_stat = 32'h0;
`endif
      bus_read(3'd5, rd);
      check("capture_value", rd, exp_cap);
      bus_read(3'd4, rd);
      check("capture_status", rd, exp_stat);
      cap_in = 1'b0;
      bus_write(3'd4, 32'h3);

      // Reset mid-count aborts everything until EN is written again.
      bus_write(3'd3, 32'd3);
      bus_write(3'd0, 32'h7);
      tick_cycle();
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      irq_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick_cycle();
         if (irq) irq_seen = 1'b1;
      end
      check("midreset_no_irq", {31'b0, irq_seen}, 32'h0);
      bus_read(3'd0, rd);
      check("midreset_ctrl", rd, 32'h0);
      bus_read(3'd3, rd);
      check("midreset_count", rd, 32'h0);
      bus_read(3'd2, rd);
      check("midreset_load", rd, 32'hFFFF_FFFF);
      bus_read(3'd4, rd);
      check("midreset_status", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
